// File: rtl/pipe_ctrl.sv
// pipe_ctrl: IF/ID/EX/MEM stall, bubble, flush and PC-redirect sequencer with a saturating stall counter.
// Define PIPE_CTRL_FWD_EN when EX/MEM forwarding exists; only load-use hazards then stall.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_valid_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             mem_valid_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             bubble_id_ex_o,
  output logic             flush_if_id_o,
  output logic             pc_load_o,
  output logic [31:0]      pc_load_addr_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             freeze, redirect, hazard, ex_hit, mem_hit, unused_ok;
  always_comb begin
    freeze   = dmem_req_i & !dmem_ready_i;
    redirect = !freeze & ex_valid_i & jump_i;
    ex_hit   = ex_valid_i & (ex_rd_i != 5'd0) & (ex_rd_i == id_rs1_i | ex_rd_i == id_rs2_i);
`ifdef PIPE_CTRL_FWD_EN
    ex_hit    = ex_hit & ex_is_load_i;
    mem_hit   = 1'b0;
    unused_ok = ^{mem_valid_i, mem_rd_i};
`else
    mem_hit   = mem_valid_i & (mem_rd_i != 5'd0) & (mem_rd_i == id_rs1_i | mem_rd_i == id_rs2_i);
    unused_ok = ex_is_load_i;
`endif
    hazard         = !freeze & !redirect & id_valid_i & (ex_hit | mem_hit);
    stall_pc_o     = rst_n & (freeze | hazard);
    stall_if_id_o  = stall_pc_o;
    stall_id_ex_o  = rst_n & freeze;
    bubble_id_ex_o = rst_n & (redirect | hazard);
    flush_if_id_o  = rst_n & !freeze & (redirect | state_q == FLUSH);
    pc_load_o      = rst_n & redirect;
    pc_load_addr_o = pc_load_o ? jump_addr_i : 32'd0;
    state_o        = state_q;
    stall_cnt_o    = stall_cnt_q;
    state_d = freeze ? MEM_WAIT
            : redirect ? (FLUSH_CYCLES == 0 ? RUN : FLUSH)
            : (state_q == FLUSH && cnt_q != 4'd1) ? FLUSH : RUN;
    cnt_d   = freeze ? 4'd0 : redirect ? 4'(FLUSH_CYCLES) : state_q == FLUSH ? cnt_q - 4'd1 : 4'd0;
    stall_cnt_d = (stall_pc_o & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
